// File: rtl/aoc_c8_pkg.sv
// rtl/aoc_c8_pkg.sv - shared types and sizes for the day-8 circuit solver
//
// Holds the default point-store depth and coordinate width, the derived
// index and distance widths, the point and connection records exchanged
// with the sort_node chain, the pair generator FSM encoding and a width
// helper used by the arithmetic pipeline.

package aoc_c8_pkg;

   localparam int NUM_POINTS = 1000;
   localparam int DIM_W      = 17;
   localparam int IDX_W      = $clog2(NUM_POINTS);
   localparam int DIST_W     = 2*DIM_W + 2;

   typedef struct packed {
      logic [DIM_W-1:0] x;
      logic [DIM_W-1:0] y;
      logic [DIM_W-1:0] z;
   } point_t;

   typedef struct packed {
      logic [DIST_W-1:0] distance;
      logic [IDX_W-1:0]  pointa;
      logic [IDX_W-1:0]  pointb;
   } conn_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Three squares of dim_w-bit values fit in 2*dim_w+2 bits without overflow.
   function automatic int dist_w(input int dim_w);
      return 2*dim_w + 2;
   endfunction

endpackage

// File: rtl/sq_dist_pipe.sv
// rtl/sq_dist_pipe.sv - squared Euclidean distance pipeline, 3-cycle latency
//
// Stages:
//   S2  per-axis absolute difference (DIM_W bits)
//   S3  per-axis square (2*DIM_W bits)
//   S4  three-way sum (DIST_W bits), registered into the output
// Valid, last-beat flag and both point indices travel alongside the data.
// The output registers hold their value while out_vld is low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_vld, in_last       input beat qualifier and final-pair flag
//   in_a_idx, in_b_idx    point indices of the pair
//   in_pa, in_pb          packed {x,y,z} coordinates of both points
//   out_vld, out_last     delayed qualifier and final-pair flag
//   out_dist              dx^2 + dy^2 + dz^2
//   out_a_idx, out_b_idx  delayed point indices

module sq_dist_pipe
   import aoc_c8_pkg::*;
#(
   parameter int  DIM_W  = aoc_c8_pkg::DIM_W,
   parameter int  IDX_W  = aoc_c8_pkg::IDX_W,
   localparam int DIST_W = dist_w(DIM_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_vld,
   input  logic               in_last,
   input  logic [IDX_W-1:0]   in_a_idx,
   input  logic [IDX_W-1:0]   in_b_idx,
   input  logic [3*DIM_W-1:0] in_pa,
   input  logic [3*DIM_W-1:0] in_pb,
   output logic               out_vld,
   output logic               out_last,
   output logic [DIST_W-1:0]  out_dist,
   output logic [IDX_W-1:0]   out_a_idx,
   output logic [IDX_W-1:0]   out_b_idx
);

   function automatic logic [DIM_W-1:0] abs_diff(input logic [DIM_W-1:0] a,
                                                  input logic [DIM_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   // Operand is widened first so the product keeps all 2*DIM_W bits.
   function automatic logic [2*DIM_W-1:0] square(input logic [DIM_W-1:0] v);
      logic [2*DIM_W-1:0] w;
      w = {{DIM_W{1'b0}}, v};
      return w * w;
   endfunction

   logic               s2_vld, s2_last;
   logic [IDX_W-1:0]   s2_a_idx, s2_b_idx;
   logic [DIM_W-1:0]   s2_dx, s2_dy, s2_dz;

   logic               s3_vld, s3_last;
   logic [IDX_W-1:0]   s3_a_idx, s3_b_idx;
   logic [2*DIM_W-1:0] s3_sx, s3_sy, s3_sz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld    <= 1'b0;
         s2_last   <= 1'b0;
         s2_a_idx  <= '0;
         s2_b_idx  <= '0;
         s2_dx     <= '0;
         s2_dy     <= '0;
         s2_dz     <= '0;
         s3_vld    <= 1'b0;
         s3_last   <= 1'b0;
         s3_a_idx  <= '0;
         s3_b_idx  <= '0;
         s3_sx     <= '0;
         s3_sy     <= '0;
         s3_sz     <= '0;
         out_vld   <= 1'b0;
         out_last  <= 1'b0;
         out_dist  <= '0;
         out_a_idx <= '0;
         out_b_idx <= '0;
      end else begin
         s2_vld   <= in_vld;
         s2_last  <= in_vld && in_last;
         s2_a_idx <= in_a_idx;
         s2_b_idx <= in_b_idx;
         s2_dx    <= abs_diff(in_pa[3*DIM_W-1 -: DIM_W], in_pb[3*DIM_W-1 -: DIM_W]);
         s2_dy    <= abs_diff(in_pa[2*DIM_W-1 -: DIM_W], in_pb[2*DIM_W-1 -: DIM_W]);
         s2_dz    <= abs_diff(in_pa[DIM_W-1:0],          in_pb[DIM_W-1:0]);

         s3_vld   <= s2_vld;
         s3_last  <= s2_last;
         s3_a_idx <= s2_a_idx;
         s3_b_idx <= s2_b_idx;
         s3_sx    <= square(s2_dx);
         s3_sy    <= square(s2_dy);
         s3_sz    <= square(s2_dz);

         out_vld  <= s3_vld;
         out_last <= s3_last;
         if (s3_vld) begin
            out_dist  <= DIST_W'(s3_sx) + DIST_W'(s3_sy) + DIST_W'(s3_sz);
            out_a_idx <= s3_a_idx;
            out_b_idx <= s3_b_idx;
         end
      end
   end

endmodule

// File: rtl/pair_dist_gen.sv
// rtl/pair_dist_gen.sv - point store and pair enumerator feeding the sort chain
//
// Loads up to NUM_POINTS 3-D points while idle, then on start enumerates
// every unordered pair (i<j) in lexicographic order, one per cycle, and
// streams {distance, pointa, pointb} into the sort chain. After the last
// beat leaves, done pulses and sort_read rises and stays high until the
// next accepted start.
//
// Optional build macro PAIR_DIST_GEN_CNT_EN adds the pair_cnt output, a
// running count of conn_out_vld beats cleared on accepted start.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   pt_clr         empty the point store (idle only; wins over pt_in_vld)
//   pt_in_vld      append pt_in to the store (idle only)
//   pt_in          packed {x,y,z} unsigned coordinates
//   start          begin pair enumeration (needs at least two points)
//   busy           high while enumerating or flushing the pipeline
//   done           one-cycle pulse after the final beat
//   load_ovf       sticky, a point was dropped on a full store
//   conn_out       {distance, pointa, pointb}, holds while not valid
//   conn_out_vld   conn_out qualifier, no backpressure
//   sort_read      read level to the sort chain
//   pair_cnt       beat counter (PAIR_DIST_GEN_CNT_EN only)

module pair_dist_gen
   import aoc_c8_pkg::*;
#(
   parameter int  NUM_POINTS = aoc_c8_pkg::NUM_POINTS,
   parameter int  DIM_W      = aoc_c8_pkg::DIM_W,
   localparam int IDX_W      = $clog2(NUM_POINTS),
   localparam int DIST_W     = dist_w(DIM_W),
   localparam int CNT_W      = $clog2(NUM_POINTS*(NUM_POINTS-1)/2 + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pt_clr,
   input  logic                      pt_in_vld,
   input  logic [3*DIM_W-1:0]        pt_in,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      load_ovf,
   output logic [DIST_W+2*IDX_W-1:0] conn_out,
   output logic                      conn_out_vld,
   output logic                      sort_read
`ifdef PAIR_DIST_GEN_CNT_EN
   ,
   output logic [CNT_W-1:0]          pair_cnt
`endif
);

   // pt_cnt must reach NUM_POINTS itself, so it may be one bit wider than an index.
   localparam int PC_W = $clog2(NUM_POINTS + 1);
   localparam int PT_W = 3*DIM_W;

   state_t            state;
   logic [PC_W-1:0]   pt_cnt;
   logic [PC_W-1:0]   i_idx, j_idx;

   logic [PT_W-1:0]   mem [NUM_POINTS];
   logic [PT_W-1:0]   s1_pa, s1_pb;
   logic              s1_vld, s1_last;
   logic [IDX_W-1:0]  s1_a_idx, s1_b_idx;

   logic              issue_last, start_ok, mem_we;
   logic              pipe_vld, pipe_last;
   logic [DIST_W-1:0] pipe_dist;
   logic [IDX_W-1:0]  pipe_a, pipe_b;

   assign issue_last = (i_idx == pt_cnt - PC_W'(2)) && (j_idx == pt_cnt - PC_W'(1));

   // pt_clr beats start, and an accepted start swallows a same-cycle load so
   // pt_cnt cannot move under the enumeration.
   assign start_ok = (state == ST_IDLE) && start && !pt_clr && (pt_cnt >= PC_W'(2));
   assign mem_we   = (state == ST_IDLE) && pt_in_vld && !pt_clr && !start_ok &&
                     (pt_cnt < PC_W'(NUM_POINTS));

   // Point RAM: single write port, two registered read ports (stage S1).
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[pt_cnt[IDX_W-1:0]] <= pt_in;
      s1_pa <= mem[i_idx[IDX_W-1:0]];
      s1_pb <= mem[j_idx[IDX_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pt_cnt    <= '0;
         i_idx     <= '0;
         j_idx     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         load_ovf  <= 1'b0;
         sort_read <= 1'b0;
         s1_vld    <= 1'b0;
         s1_last   <= 1'b0;
         s1_a_idx  <= '0;
         s1_b_idx  <= '0;
      end else begin
         done     <= 1'b0;
         s1_vld   <= (state == ST_RUN);
         s1_last  <= (state == ST_RUN) && issue_last;
         s1_a_idx <= i_idx[IDX_W-1:0];
         s1_b_idx <= j_idx[IDX_W-1:0];

         case (state)
            ST_IDLE: begin
               if (pt_clr) begin
                  pt_cnt   <= '0;
                  load_ovf <= 1'b0;
               end else if (start_ok) begin
                  state     <= ST_RUN;
                  busy      <= 1'b1;
                  sort_read <= 1'b0;
                  i_idx     <= '0;
                  j_idx     <= PC_W'(1);
               end else if (pt_in_vld) begin
                  if (pt_cnt < PC_W'(NUM_POINTS))
                     pt_cnt <= pt_cnt + 1'b1;
                  else
                     load_ovf <= 1'b1;
               end
            end

            ST_RUN: begin
               if (j_idx == pt_cnt - PC_W'(1)) begin
                  if (issue_last) begin
                     state <= ST_FLUSH;
                  end else begin
                     i_idx <= i_idx + 1'b1;
                     j_idx <= i_idx + PC_W'(2);
                  end
               end else begin
                  j_idx <= j_idx + 1'b1;
               end
            end

            // The final pair carries a last flag; seeing it on the output
            // means the pipeline has emptied.
            ST_FLUSH: begin
               if (pipe_vld && pipe_last) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_DRAIN;
               end
            end

            ST_DRAIN: begin
               sort_read <= 1'b1;
               state     <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   sq_dist_pipe #(
      .DIM_W (DIM_W),
      .IDX_W (IDX_W)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld    (s1_vld),
      .in_last   (s1_last),
      .in_a_idx  (s1_a_idx),
      .in_b_idx  (s1_b_idx),
      .in_pa     (s1_pa),
      .in_pb     (s1_pb),
      .out_vld   (pipe_vld),
      .out_last  (pipe_last),
      .out_dist  (pipe_dist),
      .out_a_idx (pipe_a),
      .out_b_idx (pipe_b)
   );

   assign conn_out     = {pipe_dist, pipe_a, pipe_b};
   assign conn_out_vld = pipe_vld;

`ifdef PAIR_DIST_GEN_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pair_cnt <= '0;
      else if (start_ok)
         pair_cnt <= '0;
      else if (pipe_vld)
         pair_cnt <= pair_cnt + 1'b1;
   end

   always @(posedge clk) begin
      if (rst_n && done)
         assert (int'(pair_cnt) == int'(pt_cnt) * (int'(pt_cnt) - 1) / 2);
   end
`endif

endmodule

// File: tb/tb_pair_dist_gen.sv
// tb/tb_pair_dist_gen.sv - directed self-checking bench for pair_dist_gen

module tb_pair_dist_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pt_clr = 1'b0;
   logic        pt_in_vld = 1'b0;
   logic        start = 1'b0;
   logic [50:0] pt_in = '0;

   logic        busy0, done0, ovf0, vld0, sr0;
   logic [55:0] conn0;
   logic        busy4, done4, ovf4, vld4, sr4;
   logic [39:0] conn4;
`ifdef PAIR_DIST_GEN_CNT_EN
   logic [18:0] pc0;
   logic [2:0]  pc4;
`endif

   int n_vec = 0;
   int n_err = 0;

   longint px[64], py[64], pz[64];
   int     npts = 0;

   longint q_d[$];
   int     q_a[$], q_b[$], q_c[$];
   longint e_d[$];
   int     e_a[$], e_b[$];
   int     done_cyc, done_cnt, sr_cyc, busy_first, busy_hi;

   always #5 clk = ~clk;

   pair_dist_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pt_clr       (pt_clr),
      .pt_in_vld    (pt_in_vld),
      .pt_in        (pt_in),
      .start        (start),
      .busy         (busy0),
      .done         (done0),
      .load_ovf     (ovf0),
      .conn_out     (conn0),
      .conn_out_vld (vld0),
      .sort_read    (sr0)
`ifdef PAIR_DIST_GEN_CNT_EN
      ,
      .pair_cnt     (pc0)
`endif
   );

   pair_dist_gen #(.NUM_POINTS(4)) dut4 (
      .clk          (clk),
      .rst_n        (rst_n),
      .pt_clr       (pt_clr),
      .pt_in_vld    (pt_in_vld),
      .pt_in        (pt_in),
      .start        (start),
      .busy         (busy4),
      .done         (done4),
      .load_ovf     (ovf4),
      .conn_out     (conn4),
      .conn_out_vld (vld4),
      .sort_read    (sr4)
`ifdef PAIR_DIST_GEN_CNT_EN
      ,
      .pair_cnt     (pc4)
`endif
   );

   function automatic longint sqd(input int a, input int b);
      longint dx, dy, dz;
      dx = px[a] - px[b];
      dy = py[a] - py[b];
      dz = pz[a] - pz[b];
      return dx*dx + dy*dy + dz*dz;
   endfunction

   function automatic void build_expected(input int n);
      e_d.delete(); e_a.delete(); e_b.delete();
      for (int i = 0; i < n; i++)
         for (int j = i + 1; j < n; j++) begin
            e_d.push_back(sqd(i, j));
            e_a.push_back(i);
            e_b.push_back(j);
         end
   endfunction

   task automatic load_point(input longint x, input longint y, input longint z);
      px[npts] = x; py[npts] = y; pz[npts] = z;
      npts++;
      pt_in = {x[16:0], y[16:0], z[16:0]};
      pt_in_vld = 1'b1;
      @(posedge clk); #1;
      pt_in_vld = 1'b0;
   endtask

   task automatic clear_points();
      pt_clr = 1'b1;
      @(posedge clk); #1;
      pt_clr = 1'b0;
      npts = 0;
   endtask

   // Pulses start, then records every cycle k (k=1 is the cycle after start
   // is sampled) for ncyc cycles. sel picks the default or the 4-point DUT.
   task automatic run_collect(input int sel, input int ncyc, input bit inject);
      logic   v, dn, sr, bz;
      longint d;
      int     a, b;
      q_d.delete(); q_a.delete(); q_b.delete(); q_c.delete();
      done_cyc = -1; done_cnt = 0; sr_cyc = -1; busy_first = 0; busy_hi = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (sel == 0) begin
            v = vld0; dn = done0; sr = sr0; bz = busy0;
            d = longint'(conn0[55:20]); a = int'(conn0[19:10]); b = int'(conn0[9:0]);
         end else begin
            v = vld4; dn = done4; sr = sr4; bz = busy4;
            d = longint'(conn4[39:4]); a = int'(conn4[3:2]); b = int'(conn4[1:0]);
         end
         if (v) begin
            q_d.push_back(d); q_a.push_back(a); q_b.push_back(b); q_c.push_back(k);
         end
         if (dn) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (sr && sr_cyc < 0) sr_cyc = k;
         if (bz) busy_hi++;
         if (k == 1) busy_first = int'(bz);
         if (inject) begin
            start     = (k == 3);
            pt_in_vld = (k == 3);
            pt_in     = '1;
            pt_clr    = (k == 4);
         end
      end
      start = 1'b0; pt_in_vld = 1'b0; pt_clr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++; if (conn0 !== '0)  begin n_err++; $display("FAIL reset_conn_out got %0h want 0", conn0); end
      n_vec++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL reset_conn_out_vld got %b want 0", vld0); end
      n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy0); end
      n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done0); end
      n_vec++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL reset_load_ovf got %b want 0", ovf0); end
      n_vec++; if (sr0 !== 1'b0)  begin n_err++; $display("FAIL reset_sort_read got %b want 0", sr0); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      longint xd[3];
      int     xa[3], xb[3];
      xd = '{9, 25, 12}; xa = '{0, 0, 1}; xb = '{1, 2, 2};
      clear_points();
      load_point(0, 0, 0);
      load_point(1, 2, 2);
      load_point(3, 0, 4);
      run_collect(0, 20, 1'b0);
      n_vec++;
      if (q_d.size() != 3) begin n_err++; $display("FAIL basic_beats got %0d want 3", q_d.size()); end
      for (int m = 0; m < 3 && m < q_d.size(); m++) begin
         n_vec++;
         if (q_d[m] !== xd[m] || q_a[m] !== xa[m] || q_b[m] !== xb[m] || q_c[m] !== 5 + m) begin
            n_err++;
            $display("FAIL basic_beat%0d got (%0d,%0d,%0d)@%0d want (%0d,%0d,%0d)@%0d",
                     m, q_a[m], q_b[m], q_d[m], q_c[m], xa[m], xb[m], xd[m], 5 + m);
         end
      end
      n_vec++; if (done_cyc !== 8 || done_cnt !== 1) begin n_err++; $display("FAIL basic_done got cyc %0d cnt %0d want cyc 8 cnt 1", done_cyc, done_cnt); end
      n_vec++; if (sr_cyc !== 9) begin n_err++; $display("FAIL basic_sort_read got cyc %0d want 9", sr_cyc); end
      n_vec++; if (busy_first !== 1 || busy_hi !== 7) begin n_err++; $display("FAIL basic_busy got first %0d cycles %0d want 1 7", busy_first, busy_hi); end
      n_vec++;
      if (conn0 !== {36'd12, 10'd1, 10'd2} || vld0 !== 1'b0 || sr0 !== 1'b1) begin
         n_err++;
         $display("FAIL basic_hold got conn %0h vld %b sr %b want conn %0h vld 0 sr 1",
                  conn0, vld0, sr0, {36'd12, 10'd1, 10'd2});
      end
`ifdef PAIR_DIST_GEN_CNT_EN
      n_vec++; if (pc0 !== 19'd3) begin n_err++; $display("FAIL basic_pair_cnt got %0d want 3", pc0); end
`endif
   endtask

   task automatic test_max_coord();
      clear_points();
      load_point(0, 0, 0);
      load_point(131071, 131071, 131071);
      run_collect(0, 15, 1'b0);
      n_vec++;
      if (q_d.size() != 1) begin
         n_err++; $display("FAIL maxc_beats got %0d want 1", q_d.size());
      end else if (q_d[0] !== 64'd51538821123 || q_a[0] !== 0 || q_b[0] !== 1) begin
         n_err++;
         $display("FAIL maxc_beat got (%0d,%0d,%0d) want (0,1,51538821123)", q_a[0], q_b[0], q_d[0]);
      end
   endtask

   task automatic test_single_point();
      clear_points();
      load_point(5, 6, 7);
      run_collect(0, 15, 1'b0);
      n_vec++;
      if (q_d.size() != 0 || done_cnt != 0 || busy_hi != 0) begin
         n_err++;
         $display("FAIL single_ignored got beats %0d done %0d busy %0d want 0 0 0", q_d.size(), done_cnt, busy_hi);
      end
      load_point(1, 1, 1);
      run_collect(0, 15, 1'b0);
      n_vec++;
      if (q_d.size() != 1 || done_cnt != 1) begin
         n_err++; $display("FAIL single_second got beats %0d done %0d want 1 1", q_d.size(), done_cnt);
      end else if (q_d[0] !== 64'd77 || q_a[0] !== 0 || q_b[0] !== 1) begin
         n_err++; $display("FAIL single_beat got (%0d,%0d,%0d) want (0,1,77)", q_a[0], q_b[0], q_d[0]);
      end
   endtask

   task automatic test_overflow();
      longint xd[6];
      int     xa[6], xb[6];
      xd = '{1, 4, 9, 5, 10, 13}; xa = '{0, 0, 0, 1, 1, 2}; xb = '{1, 2, 3, 2, 3, 3};
      clear_points();
      load_point(0, 0, 0);
      load_point(1, 0, 0);
      load_point(0, 2, 0);
      load_point(0, 0, 3);
      load_point(9, 9, 9);
      n_vec++; if (ovf4 !== 1'b1 || ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_set got small %b big %b want 1 0", ovf4, ovf0); end
      run_collect(1, 30, 1'b0);
      n_vec++;
      if (q_d.size() != 6 || done_cnt != 1) begin n_err++; $display("FAIL ovf_beats got %0d done %0d want 6 1", q_d.size(), done_cnt); end
      for (int m = 0; m < 6 && m < q_d.size(); m++) begin
         n_vec++;
         if (q_d[m] !== xd[m] || q_a[m] !== xa[m] || q_b[m] !== xb[m]) begin
            n_err++;
            $display("FAIL ovf_beat%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", m, q_a[m], q_b[m], q_d[m], xa[m], xb[m], xd[m]);
         end
      end
      n_vec++; if (ovf4 !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf4); end
      clear_points();
      n_vec++; if (ovf4 !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", ovf4); end
   endtask

   task automatic test_reset_mid_run();
      int bad;
      clear_points();
      for (int p = 0; p < 10; p++) load_point(p*1000, 50000 - p*37, p*p*11);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      n_vec++; if (vld0 !== 1'b1 || busy0 !== 1'b1) begin n_err++; $display("FAIL abort_running got vld %b busy %b want 1 1", vld0, busy0); end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (conn0 !== '0 || vld0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || ovf0 !== 1'b0 || sr0 !== 1'b0) begin
         n_err++;
         $display("FAIL abort_outputs got conn %0h vld %b busy %b done %b ovf %b sr %b want all 0",
                  conn0, vld0, busy0, done0, ovf0, sr0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (vld0 || done0 || busy0) bad++;
      end
      @(posedge clk); #1;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL abort_quiet got %0d active cycles want 0", bad); end
      clear_points();
      for (int p = 0; p < 10; p++) load_point(p*1000, 50000 - p*37, p*p*11);
      build_expected(10);
      run_collect(0, 70, 1'b0);
      n_vec++;
      if (q_d.size() != 45 || done_cnt != 1) begin n_err++; $display("FAIL abort_rerun got beats %0d done %0d want 45 1", q_d.size(), done_cnt); end
      bad = 0;
      for (int m = 0; m < 45 && m < q_d.size(); m++)
         if (q_d[m] !== e_d[m] || q_a[m] !== e_a[m] || q_b[m] !== e_b[m] || q_c[m] !== 5 + m) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL abort_rerun_data got %0d bad beats want 0", bad); end
   endtask

   task automatic test_random50();
      clear_points();
      for (int p = 0; p < 50; p++)
         load_point(longint'($urandom_range(0, 131071)), longint'($urandom_range(0, 131071)),
                    longint'($urandom_range(0, 131071)));
      build_expected(50);
      run_collect(0, 1300, 1'b1);
      n_vec++;
      if (q_d.size() != 1225) begin n_err++; $display("FAIL rand_beats got %0d want 1225", q_d.size()); end
      for (int m = 0; m < 1225 && m < q_d.size(); m++) begin
         n_vec++;
         if (q_d[m] !== e_d[m] || q_a[m] !== e_a[m] || q_b[m] !== e_b[m] || q_c[m] !== 5 + m) begin
            n_err++;
            $display("FAIL rand_beat%0d got (%0d,%0d,%0d)@%0d want (%0d,%0d,%0d)@%0d",
                     m, q_a[m], q_b[m], q_d[m], q_c[m], e_a[m], e_b[m], e_d[m], 5 + m);
         end
      end
      n_vec++;
      if (done_cnt != 1 || done_cyc != 1230 || sr_cyc != 1231) begin
         n_err++;
         $display("FAIL rand_done got done %0d@%0d sr@%0d want 1@1230 sr@1231", done_cnt, done_cyc, sr_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_coord();
      test_single_point();
      test_overflow();
      test_reset_mid_run();
      test_random50();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
